formula_nsqrt_sum_pipe: RTL
===========================

Name: formula_nsqrt_sum_pipe

Overview:
Parametrised N-channel pipelined "sum of integer square roots" engine: res = sum over i of isqrt(arg[i]).
- Accepts one argument vector per clock with a fixed latency. Generalises the 3-channel formula pipes to any channel count and argument width.
- Uses one isqrt instance per channel, followed by a registered pairwise adder tree.
- Sits in the arithmetic datapath wherever multi-operand sqrt-sum formulas are needed.

Parameters:
- N_CH, 3, number of channels (1..16).
- W, 32, argument width per channel (even, 8..64).
- ISQRT_STAGES, 4, n_pipe_stages passed to every isqrt instance. isqrt y_vld follows x_vld by exactly ISQRT_STAGES cycles.
- Derived, not overridable: TREE_D = max(1, clog2(N_CH)); RES_W = W/2 + clog2(N_CH) (N_CH=1 gives W/2); LAT = ISQRT_STAGES + TREE_D.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- arg_vld  in  1  argument vector valid, one per cycle, no backpressure.
- args  in  N_CH*W  channel i at args[i*W +: W].
- res_vld  out  1  result valid.
- res  out  RES_W  sum of channel square roots.
- busy  out  1  high while any valid is in flight inside the block (registered).

Behaviour:
- Reset (asynchronous assert):
  - res_vld=0, res=0, busy=0.
  - All tree valid flags cleared; all isqrt instances reset via rst.
  - Reset mid-operation discards every in-flight item. No res_vld occurs for items accepted before reset.
- Issue: arg_vld drives x_vld of all N_CH isqrt instances directly. Valid may be high every cycle; bubbles are allowed anywhere.
- Latency: res_vld rises exactly LAT cycles after the arg_vld cycle. Results appear in order, one per accepted vector, with no gaps beyond the input gaps.
- Tree:
  - Level 0 inputs are the isqrt outputs (W/2 bits each), zero-extended to RES_W.
  - Each level sums adjacent pairs (2k, 2k+1); an odd leftover passes through unchanged.
  - Each level output is registered, and each level carries its own valid flag.
  - N_CH=1 still has one register level (TREE_D=1).
- Level-0 valid is the AND of all isqrt y_vld. The instances are identical, so a mismatch cannot occur in correct operation.
- Power: every tree data register loads only when its level input valid is 1. It holds its value otherwise, so no toggling on bubbles. Valid flags update every cycle.
- res holds the last valid result while res_vld=0. After reset it holds 0 until the first result.
- Width: RES_W is sized so no overflow occurs. Worst case is N_CH*(2^(W/2)-1); no wrap or saturation logic.
- busy = OR of arg_vld registered, isqrt-stage occupancy and tree valid flags. Internal count of in-flight items: increment on accept, decrement on res_vld, simultaneous accept+retire keeps it unchanged. busy = (count != 0). The counter never exceeds LAT.

Optional Feature:
FORMULA_NSQRT_MASK_EN
- Defined: adds input arg_mask [N_CH-1:0], sampled with arg_vld and pipelined alongside the isqrt latency (ISQRT_STAGES-deep mask shift register, loaded only on valid). Masked channels contribute 0 at level 0. A mask of all zeros yields res=0 with res_vld still asserted; latency unchanged.
- Undefined: no arg_mask port; all channels always summed.

Decomposition:
- Package formula_nsqrt_pkg: clog2-based helper functions for TREE_D, RES_W and LAT; the per-level width type; the maximum N_CH constant.
- Sub-module nsqrt_adder_tree_pipe (params N_IN, IN_W, OUT_W): registered pairwise reduction with per-level valid and valid-gated data loads.
- Top level holds the isqrt generate loop, the optional mask pipeline and the busy counter.

Test Plan (defaults N_CH=3, W=32, ISQRT_STAGES=4, LAT=6, RES_W=18):
- Single vector a=16, b=25, c=100 at cycle 0 -> res_vld exactly at cycle 6, res=19, busy high for cycles 1..6.
- All args 32'hFFFFFFFF -> res=196605 (3*65535), no overflow in 18 bits.
- 20 back-to-back random vectors, then 10 with random bubbles -> in-order results matching a reference model, res_vld pattern equal to arg_vld delayed 6 cycles.
- Bubble hold: vector (0,1,4) then arg_vld low 10 cycles -> res=3 once, then res stays 3 with res_vld=0 and no tree register toggles.
- Async rst pulse while 3 items are in flight -> outputs 0 immediately, no res_vld for those items; a new vector after release gives the correct result at LAT.
- With FORMULA_NSQRT_MASK_EN: args (9,16,25), mask 3'b101 -> res=8; mask 3'b000 -> res_vld=1, res=0.

Source files
------------

// File: rtl/formula_nsqrt_pkg.sv
// rtl/formula_nsqrt_pkg.sv - shared sizing helpers for the N-channel sqrt-sum pipe
package formula_nsqrt_pkg;

    localparam int MAX_N_CH = 16;

    typedef int unsigned width_t;

    function automatic width_t tree_depth(input width_t n_ch);
        return (n_ch <= 1) ? 1 : width_t'($clog2(n_ch));
    endfunction

    function automatic width_t res_width(input width_t n_ch, input width_t w);
        return w / 2 + width_t'($clog2(n_ch));
    endfunction

    function automatic width_t pipe_latency(input width_t n_ch, input width_t stages);
        return stages + tree_depth(n_ch);
    endfunction

    // Node count after lvl pairwise reductions; an odd leftover survives each level.
    function automatic width_t level_nodes(input width_t n_in, input width_t lvl);
        width_t n;
        n = n_in;
        for (width_t i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

endpackage

// File: rtl/isqrt.sv
// rtl/isqrt.sv - integer square root with a fixed N_PIPE_STAGES-cycle valid latency
module isqrt #(
    parameter int W             = 32,
    parameter int N_PIPE_STAGES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_vld,
    input  logic [W-1:0]   x,
    output logic           y_vld,
    output logic [W/2-1:0] y
);
    localparam int HALF = W / 2;

    // Restoring digit-by-digit root, two argument bits per result bit.
    function automatic logic [HALF-1:0] root_of(input logic [W-1:0] v);
        logic [HALF+1:0] rem;
        logic [HALF+1:0] trial;
        logic [HALF-1:0] r;
        rem = '0;
        r   = '0;
        for (int i = HALF - 1; i >= 0; i--) begin
            rem   = {rem[HALF-1:0], v[2*i +: 2]};
            trial = {r, 2'b01};
            if (rem >= trial) begin
                rem = rem - trial;
                r   = {r[HALF-2:0], 1'b1};
            end else begin
                r   = {r[HALF-2:0], 1'b0};
            end
        end
        return r;
    endfunction

    logic [HALF-1:0]          stage_q [N_PIPE_STAGES];
    logic [N_PIPE_STAGES-1:0] vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < N_PIPE_STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= x_vld;
            if (x_vld) begin
                stage_q[0] <= root_of(x);
            end
            for (int s = 1; s < N_PIPE_STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    stage_q[s] <= stage_q[s-1];
                end
            end
        end
    end

    assign y_vld = vld_q[N_PIPE_STAGES-1];
    assign y     = stage_q[N_PIPE_STAGES-1];

endmodule

// File: rtl/nsqrt_adder_tree_pipe.sv
// rtl/nsqrt_adder_tree_pipe.sv - registered pairwise reduction tree with per-level valid
module nsqrt_adder_tree_pipe
    import formula_nsqrt_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int IN_W  = 16,
    parameter int OUT_W = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [N_IN*IN_W-1:0] in_data,
    output logic                 out_vld,
    output logic [OUT_W-1:0]     out_data
);
    localparam int DEPTH = int'(tree_depth(N_IN));

    for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
        localparam int CNT = int'(level_nodes(N_IN, l));

        logic [OUT_W-1:0] node [CNT];
        logic             vld;

        if (l == 0) begin : g_in
            assign vld = in_vld;
            always_comb begin
                for (int k = 0; k < CNT; k++) begin
                    node[k] = OUT_W'(in_data[k*IN_W +: IN_W]);
                end
            end
        end else begin : g_reg
            localparam int PCNT = int'(level_nodes(N_IN, l - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= 1'b0;
                end else begin
                    vld <= g_lvl[l-1].vld;
                end
            end

            // Data only loads on a valid input so bubbles leave the tree quiet.
            for (genvar k = 0; k < CNT; k++) begin : g_node
                if (2 * k + 1 < PCNT) begin : g_pair
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            node[k] <= '0;
                        end else if (g_lvl[l-1].vld) begin
                            node[k] <= g_lvl[l-1].node[2*k] + g_lvl[l-1].node[2*k+1];
                        end
                    end
                end else begin : g_pass
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            node[k] <= '0;
                        end else if (g_lvl[l-1].vld) begin
                            node[k] <= g_lvl[l-1].node[2*k];
                        end
                    end
                end
            end
        end
    end

    assign out_vld  = g_lvl[DEPTH].vld;
    assign out_data = g_lvl[DEPTH].node[0];

endmodule

// File: rtl/formula_nsqrt_sum_pipe.sv
// rtl/formula_nsqrt_sum_pipe.sv - N-channel pipelined sum of isqrt; FORMULA_NSQRT_MASK_EN adds arg_mask
module formula_nsqrt_sum_pipe
    import formula_nsqrt_pkg::*;
#(
    parameter  int N_CH         = 3,
    parameter  int W            = 32,
    parameter  int ISQRT_STAGES = 4,
    localparam int RES_W        = int'(res_width(N_CH, W))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arg_vld,
    input  logic [N_CH*W-1:0] args,
`ifdef FORMULA_NSQRT_MASK_EN
    input  logic [N_CH-1:0]   arg_mask,
`endif
    output logic              res_vld,
    output logic [RES_W-1:0]  res,
    output logic              busy
);
    localparam int HALF  = W / 2;
    localparam int LAT   = int'(pipe_latency(N_CH, ISQRT_STAGES));
    localparam int CNT_W = $clog2(LAT + 1);

    logic [N_CH-1:0]      y_vld;
    logic [HALF-1:0]      root [N_CH];
    logic [N_CH*HALF-1:0] tree_in;
    logic                 tree_in_vld;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        isqrt #(
            .W             (W),
            .N_PIPE_STAGES (ISQRT_STAGES)
        ) u_isqrt (
            .clk   (clk),
            .rst   (rst),
            .x_vld (arg_vld),
            .x     (args[i*W +: W]),
            .y_vld (y_vld[i]),
            .y     (root[i])
        );
    end

`ifdef FORMULA_NSQRT_MASK_EN
    // Mask travels beside the isqrt pipeline so it lines up with each root.
    logic [N_CH-1:0]         mask_q [ISQRT_STAGES];
    logic [ISQRT_STAGES-1:0] mask_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_v <= '0;
            for (int s = 0; s < ISQRT_STAGES; s++) begin
                mask_q[s] <= '0;
            end
        end else begin
            mask_v[0] <= arg_vld;
            if (arg_vld) begin
                mask_q[0] <= arg_mask;
            end
            for (int s = 1; s < ISQRT_STAGES; s++) begin
                mask_v[s] <= mask_v[s-1];
                if (mask_v[s-1]) begin
                    mask_q[s] <= mask_q[s-1];
                end
            end
        end
    end

    always_comb begin
        tree_in = '0;
        for (int i = 0; i < N_CH; i++) begin
            tree_in[i*HALF +: HALF] = mask_q[ISQRT_STAGES-1][i] ? root[i] : '0;
        end
        tree_in_vld = (&y_vld) & mask_v[ISQRT_STAGES-1];
    end
`else
    always_comb begin
        tree_in = '0;
        for (int i = 0; i < N_CH; i++) begin
            tree_in[i*HALF +: HALF] = root[i];
        end
        tree_in_vld = &y_vld;
    end
`endif

    nsqrt_adder_tree_pipe #(
        .N_IN  (N_CH),
        .IN_W  (HALF),
        .OUT_W (RES_W)
    ) u_tree (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (tree_in_vld),
        .in_data  (tree_in),
        .out_vld  (res_vld),
        .out_data (res)
    );

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        case ({arg_vld, res_vld})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= count_next;
            busy  <= (count_next != '0);
        end
    end

endmodule
